// File: rtl/biriscv_csr_commit_pkg.sv
// biriscv_csr_commit_pkg
//   Shared definitions for the CSR commit path (E2 -> WB):
//   exception code width and codes, plus the packed stage payload
//   carried by both the E2 and WB slots.
package biriscv_csr_commit_pkg;

    localparam int CSR_EXC_W   = 6;
    localparam int CSR_ADDR_W  = 32;
    localparam int CSR_WADDR_W = 12;

    localparam logic [CSR_EXC_W-1:0] EXC_NONE                = 6'h00;
    localparam logic [CSR_EXC_W-1:0] EXC_MISALIGNED_FETCH    = 6'h10;
    localparam logic [CSR_EXC_W-1:0] EXC_FAULT_FETCH         = 6'h11;
    localparam logic [CSR_EXC_W-1:0] EXC_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [CSR_EXC_W-1:0] EXC_BREAKPOINT          = 6'h13;
    localparam logic [CSR_EXC_W-1:0] EXC_MISALIGNED_LOAD     = 6'h14;
    localparam logic [CSR_EXC_W-1:0] EXC_FAULT_LOAD          = 6'h15;
    localparam logic [CSR_EXC_W-1:0] EXC_MISALIGNED_STORE    = 6'h16;
    localparam logic [CSR_EXC_W-1:0] EXC_FAULT_STORE         = 6'h17;
    localparam logic [CSR_EXC_W-1:0] EXC_ECALL               = 6'h18;
    localparam logic [CSR_EXC_W-1:0] EXC_ERET_U              = 6'h30;
    localparam logic [CSR_EXC_W-1:0] EXC_ERET_S              = 6'h31;
    localparam logic [CSR_EXC_W-1:0] EXC_ERET_H              = 6'h32;
    localparam logic [CSR_EXC_W-1:0] EXC_ERET_M              = 6'h33;
    localparam logic [CSR_EXC_W-1:0] EXC_FENCE               = 6'h34;

    // value holds the CSR read result, or the xtval source once an
    // exception is attached (faulting opcode or fault data address).
    typedef struct packed {
        logic                   valid;
        logic [CSR_ADDR_W-1:0]  pc;
        logic [CSR_WADDR_W-1:0] waddr;
        logic                   write;
        logic [CSR_ADDR_W-1:0]  wdata;
        logic [CSR_ADDR_W-1:0]  value;
        logic [CSR_EXC_W-1:0]   exception;
    } commit_payload_t;

    function automatic logic has_exc(input commit_payload_t p);
        return p.valid && (p.exception != EXC_NONE);
    endfunction

endpackage

// File: rtl/biriscv_csr_commit_slot.sv
// biriscv_csr_commit_slot
//   One pipeline payload register. load_i captures d_i, otherwise
//   clear_i inserts a bubble (whole payload zeroed), otherwise hold.
//   Ports: clk_i, rst_ni (async active-low), load_i, clear_i, d_i, q_o.
module biriscv_csr_commit_slot
    import biriscv_csr_commit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            clear_i,
    input  commit_payload_t d_i,
    output commit_payload_t q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            q_o <= '0;
        else if (load_i)
            q_o <= d_i;
        else if (clear_i)
            q_o <= '0;
    end

endmodule

// File: rtl/biriscv_csr_commit.sv
// biriscv_csr_commit
//   Carries CSR results and early exceptions from E1 through E2 to WB,
//   merges late LSU faults in E2, and produces the one-cycle CSR
//   writeback / exception commit. A committed exception kills the E2
//   entry behind it and raises flush_o during its WB cycle.
//   Inputs : E1 payload (e1_*, csr_result_e1_*), e2_fault_i/_addr_i,
//            stall_i, squash_e1_i.
//   Outputs: csr_writeback_* commit bus, flush_o, busy_o.
//   Optional: CSR_COMMIT_INSTRET_EN adds instret_o (64-bit count of
//             clean commits).
module biriscv_csr_commit
    import biriscv_csr_commit_pkg::*;
#(
    parameter int EXCEPTION_W = CSR_EXC_W,
    parameter int ADDR_W      = CSR_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   e1_valid_i,
    input  logic [ADDR_W-1:0]      e1_pc_i,
    input  logic [11:0]            e1_waddr_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [ADDR_W-1:0]      csr_result_e1_wdata_i,
    input  logic [ADDR_W-1:0]      csr_result_e1_value_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic [EXCEPTION_W-1:0] e2_fault_i,
    input  logic [ADDR_W-1:0]      e2_fault_addr_i,
    input  logic                   stall_i,
    input  logic                   squash_e1_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [ADDR_W-1:0]      csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [ADDR_W-1:0]      csr_writeback_exception_pc_o,
    output logic [ADDR_W-1:0]      csr_writeback_exception_addr_o,
`ifdef CSR_COMMIT_INSTRET_EN
    output logic [63:0]            instret_o,
`endif
    output logic                   flush_o,
    output logic                   busy_o
);

    commit_payload_t e1_d, e2_q, e2_adv, wb_q;
    logic            kill, e2_load, e2_clear;

    always_comb begin
        e1_d           = '0;
        e1_d.valid     = 1'b1;
        e1_d.pc        = e1_pc_i;
        e1_d.waddr     = e1_waddr_i;
        e1_d.write     = csr_result_e1_write_i;
        e1_d.wdata     = csr_result_e1_wdata_i;
        e1_d.value     = csr_result_e1_value_i;
        e1_d.exception = csr_result_e1_exception_i;
    end

    // Late LSU fault only lands on a clean E2 entry; an earlier
    // exception already owns the commit.
    always_comb begin
        e2_adv = e2_q;
        if (e2_q.valid && (e2_q.exception == EXC_NONE) && (e2_fault_i != EXC_NONE)) begin
            e2_adv.exception = e2_fault_i;
            e2_adv.value     = e2_fault_addr_i;
            e2_adv.write     = 1'b0;
        end
    end

    // Kill fires on the edge an excepting entry moves to WB; flush_o
    // then covers the following cycle, so E1 is blocked for both.
    assign kill     = !stall_i && has_exc(e2_adv);
    assign flush_o  = has_exc(wb_q);
    assign e2_load  = !stall_i && e1_valid_i && !squash_e1_i && !kill && !flush_o;
    assign e2_clear = !stall_i && !e2_load;

    biriscv_csr_commit_slot u_e2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (e2_load),
        .clear_i(e2_clear),
        .d_i    (e1_d),
        .q_o    (e2_q)
    );

    // Under stall WB takes a bubble so nothing commits twice.
    biriscv_csr_commit_slot u_wb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (!stall_i),
        .clear_i(stall_i),
        .d_i    (e2_adv),
        .q_o    (wb_q)
    );

    assign csr_writeback_write_o          = wb_q.valid && wb_q.write && (wb_q.exception == EXC_NONE);
    assign csr_writeback_waddr_o          = wb_q.valid ? wb_q.waddr : '0;
    assign csr_writeback_wdata_o          = wb_q.valid ? wb_q.wdata : '0;
    assign csr_writeback_exception_o      = wb_q.valid ? wb_q.exception : '0;
    assign csr_writeback_exception_pc_o   = wb_q.valid ? wb_q.pc : '0;
    assign csr_writeback_exception_addr_o = has_exc(wb_q) ? wb_q.value : '0;
    assign busy_o                         = e2_q.valid || wb_q.valid;

`ifdef CSR_COMMIT_INSTRET_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            instret_o <= '0;
        else if (wb_q.valid && (wb_q.exception == EXC_NONE))
            instret_o <= instret_o + 64'd1;
    end
`endif

endmodule

// File: tb/tb_biriscv_csr_commit.sv
module tb_biriscv_csr_commit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        e1_valid = 0;
    logic [31:0] e1_pc = 0;
    logic [11:0] e1_waddr = 0;
    logic        e1_write = 0;
    logic [31:0] e1_wdata = 0;
    logic [31:0] e1_value = 0;
    logic [5:0]  e1_exc = 0;
    logic [5:0]  e2_fault = 0;
    logic [31:0] e2_fault_addr = 0;
    logic        stall = 0;
    logic        squash = 0;
    logic        wb_write;
    logic [11:0] wb_waddr;
    logic [31:0] wb_wdata;
    logic [5:0]  wb_exc;
    logic [31:0] wb_pc;
    logic [31:0] wb_addr;
    logic        flush;
    logic        busy;
`ifdef CSR_COMMIT_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] pc;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    biriscv_csr_commit dut (
        .clk_i                         (clk),
        .rst_ni                        (rst_ni),
        .e1_valid_i                    (e1_valid),
        .e1_pc_i                       (e1_pc),
        .e1_waddr_i                    (e1_waddr),
        .csr_result_e1_write_i         (e1_write),
        .csr_result_e1_wdata_i         (e1_wdata),
        .csr_result_e1_value_i         (e1_value),
        .csr_result_e1_exception_i     (e1_exc),
        .e2_fault_i                    (e2_fault),
        .e2_fault_addr_i               (e2_fault_addr),
        .stall_i                       (stall),
        .squash_e1_i                   (squash),
        .csr_writeback_write_o         (wb_write),
        .csr_writeback_waddr_o         (wb_waddr),
        .csr_writeback_wdata_o         (wb_wdata),
        .csr_writeback_exception_o     (wb_exc),
        .csr_writeback_exception_pc_o  (wb_pc),
        .csr_writeback_exception_addr_o(wb_addr),
`ifdef CSR_COMMIT_INSTRET_EN
        .instret_o                     (instret),
`endif
        .flush_o                       (flush),
        .busy_o                        (busy)
    );

    // Scoreboard monitor: every observed commit must match the oldest
    // expected entry; all stimulus uses nonzero PCs so a commit is visible.
    always @(negedge clk) begin
        if (rst_ni && (wb_write || wb_exc != 0 || wb_pc != 0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit pc=%h exc=%h write=%b", wb_pc, wb_exc, wb_write);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({wb_write, wb_waddr, wb_wdata, wb_exc, wb_pc, wb_addr, flush} !==
                    {e.write, e.waddr, e.wdata, e.exc, e.pc, e.addr, (e.exc != 0)}) begin
                    errors++;
                    $display("FAIL commit got w=%b a=%h d=%h exc=%h pc=%h xa=%h fl=%b exp w=%b a=%h d=%h exc=%h pc=%h xa=%h fl=%b",
                             wb_write, wb_waddr, wb_wdata, wb_exc, wb_pc, wb_addr, flush,
                             e.write, e.waddr, e.wdata, e.exc, e.pc, e.addr, (e.exc != 0));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e1(input logic [31:0] pc, input logic [11:0] wa, input logic w,
                          input logic [31:0] wd, input logic [31:0] val, input logic [5:0] exc);
        e1_valid = 1; e1_pc = pc; e1_waddr = wa; e1_write = w;
        e1_wdata = wd; e1_value = val; e1_exc = exc;
    endtask

    task automatic push_exp(input logic w, input logic [11:0] wa, input logic [31:0] wd,
                            input logic [5:0] exc, input logic [31:0] pc, input logic [31:0] xa);
        exp_t e;
        e.write = w; e.waddr = wa; e.wdata = wd; e.exc = exc; e.pc = pc; e.addr = xa;
        exp_q.push_back(e);
    endtask

    // Bounded wait for the scoreboard to empty, then a few idle cycles
    // so any stray commit is caught by the monitor.
    task automatic drain(input string name);
        int n = 0;
        e1_valid = 0;
        while (exp_q.size() != 0 && n < 20) begin step(); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle busy=%b required=0", name, busy);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({wb_write, wb_waddr, wb_wdata, wb_exc, wb_pc, wb_addr, flush, busy} !== '0) begin
            errors++;
            $display("FAIL %s outputs w=%b a=%h d=%h exc=%h pc=%h xa=%h fl=%b busy=%b required all 0",
                     name, wb_write, wb_waddr, wb_wdata, wb_exc, wb_pc, wb_addr, flush, busy);
        end
    endtask

    task automatic test_reset();
        rst_ni = 0;
        repeat (3) step();
        check_zero("reset");
        rst_ni = 1;
        step();
        check_zero("post_reset");
    endtask

    task automatic test_csr_write();
        set_e1(32'h8000_0000, 12'h300, 1, 32'h1888, 32'h0, 6'h0);
        push_exp(1, 12'h300, 32'h1888, 6'h0, 32'h8000_0000, 32'h0);
        step();
        e1_valid = 0;
        checks++;
        if (wb_write !== 1'b0) begin
            errors++;
            $display("FAIL write_latency early commit write=%b required=0", wb_write);
        end
        drain("csr_write");
    endtask

    task automatic test_illegal();
        set_e1(32'h8000_0010, 12'h0, 0, 32'h0, 32'hFFFF_FFFF, 6'h12);
        push_exp(0, 12'h0, 32'h0, 6'h12, 32'h8000_0010, 32'hFFFF_FFFF);
        step();
        // Younger write held valid through the kill and flush cycles.
        set_e1(32'h8000_0014, 12'h305, 1, 32'hDEAD, 32'h0, 6'h0);
        step();
        step();
        e1_valid = 0;
        drain("illegal");
    endtask

    task automatic test_fault_merge();
        set_e1(32'h0000_0100, 12'h340, 1, 32'h5, 32'h0, 6'h0);
        step();
        e1_valid = 0; e2_fault = 6'h5; e2_fault_addr = 32'h1234;
        push_exp(0, 12'h340, 32'h5, 6'h5, 32'h0000_0100, 32'h1234);
        step();
        e2_fault = 0; e2_fault_addr = 0;
        drain("fault_merge");
        // Existing E1 exception beats a late fault.
        set_e1(32'h0000_0200, 12'h0, 0, 32'h0, 32'hAB, 6'h18);
        step();
        e1_valid = 0; e2_fault = 6'h15; e2_fault_addr = 32'h5678;
        push_exp(0, 12'h0, 32'h0, 6'h18, 32'h0000_0200, 32'hAB);
        step();
        e2_fault = 0; e2_fault_addr = 0;
        drain("fault_priority");
    endtask

    task automatic test_stall();
        set_e1(32'h0000_0300, 12'h341, 1, 32'hCAFE, 32'h0, 6'h0);
        step();
        e1_valid = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (wb_write !== 1'b0 || wb_pc !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d write=%b pc=%h required 0", i, wb_write, wb_pc);
            end
        end
        push_exp(1, 12'h341, 32'hCAFE, 6'h0, 32'h0000_0300, 32'h0);
        @(posedge clk); #1;
        stall = 0;
        drain("stall");
    endtask

    task automatic test_squash();
        set_e1(32'h0000_0400, 12'h342, 1, 32'h77, 32'h0, 6'h0);
        squash = 1;
        step();
        squash = 0; e1_valid = 0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL squash busy=%b required=0", busy);
        end
        drain("squash");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_e1(32'h0000_1000 + 32'(i * 4), 12'(12'h340 + i), 1, 32'(i * 17 + 1), 32'h0, 6'h0);
            push_exp(1, 12'(12'h340 + i), 32'(i * 17 + 1), 6'h0, 32'h0000_1000 + 32'(i * 4), 32'h0);
            step();
        end
        e1_valid = 0;
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back pending=%0d required=0 after 4+2 cycles", exp_q.size());
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_midflight();
        set_e1(32'h0000_2000, 12'h300, 1, 32'h11, 32'h0, 6'h0);
        step();
        set_e1(32'h0000_2004, 12'h301, 1, 32'h22, 32'h0, 6'h0);
        step();
        e1_valid = 0;
        rst_ni = 0;
        #1;
        check_zero("reset_midflight");
        step();
        rst_ni = 1;
        drain("reset_midflight");
    endtask

    task automatic test_instret();
`ifdef CSR_COMMIT_INSTRET_EN
        rst_ni = 0;
        step();
        rst_ni = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            set_e1(32'h0000_3000 + 32'(i * 4), 12'h340, 0, 32'h0, 32'h0, 6'h0);
            push_exp(0, 12'h340, 32'h0, 6'h0, 32'h0000_3000 + 32'(i * 4), 32'h0);
            step();
        end
        set_e1(32'h0000_3100, 12'h0, 0, 32'h0, 32'h0, 6'h13);
        push_exp(0, 12'h0, 32'h0, 6'h13, 32'h0000_3100, 32'h0);
        step();
        drain("instret");
        checks++;
        if (instret !== 64'd5) begin
            errors++;
            $display("FAIL instret got=%0d required=5", instret);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_csr_write();
        test_illegal();
        test_fault_merge();
        test_stall();
        test_squash();
        test_back_to_back();
        test_reset_midflight();
        test_instret();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
